// File: rtl/fp16_adder.sv
// IEEE-754 binary16 adder, z = a + b, round-to-nearest-even.
// One operation in flight; operands and result on stb/ack streams.
module fp16_adder #(
  parameter logic [15:0] QNAN = 16'h7e00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [15:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [15:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [3:0] GET_A   = 4'd0;
  localparam logic [3:0] GET_B   = 4'd1;
  localparam logic [3:0] UNPACK  = 4'd2;
  localparam logic [3:0] SPECIAL = 4'd3;
  localparam logic [3:0] ALIGN   = 4'd4;
  localparam logic [3:0] ADD     = 4'd5;
  localparam logic [3:0] NORM_0  = 4'd6;
  localparam logic [3:0] NORM_1  = 4'd7;
  localparam logic [3:0] ROUND   = 4'd8;
  localparam logic [3:0] PACK    = 4'd9;
  localparam logic [3:0] PUT_Z   = 4'd10;

  localparam logic signed [6:0] EMIN = -7'sd14;
  localparam logic signed [6:0] EMAX = 7'sd15;

  logic [3:0]        state_q, state_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              z_stb_q, z_stb_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [15:0]       z_q, z_d;
  logic [13:0]       a_m_q, a_m_d;
  logic [13:0]       b_m_q, b_m_d;
  logic signed [6:0] a_e_q, a_e_d;
  logic signed [6:0] b_e_q, b_e_d;
  logic [14:0]       s_m_q, s_m_d;
  logic signed [6:0] s_e_q, s_e_d;
  logic              s_s_q, s_s_d;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [14:0] add_sum;
  logic        add_sign;
  logic [11:0] rnd;
  logic        rnd_up;

  assign a_nan  = (&a_q[14:10]) & (|a_q[9:0]);
  assign b_nan  = (&b_q[14:10]) & (|b_q[9:0]);
  assign a_inf  = (&a_q[14:10]) & ~(|a_q[9:0]);
  assign b_inf  = (&b_q[14:10]) & ~(|b_q[9:0]);
  assign a_zero = ~(|a_q[14:0]);
  assign b_zero = ~(|b_q[14:0]);

  // Round increment on the 11 kept bits; bit 11 is the carry out.
  assign rnd    = {1'b0, s_m_q[13:3]} + 12'd1;
  assign rnd_up = s_m_q[2] & (s_m_q[1] | s_m_q[0] | s_m_q[3]);

  // Signed-magnitude add of the aligned mantissas; exact zero is +0.
  always_comb begin
    add_sum  = '0;
    add_sign = 1'b0;
    if (a_q[15] == b_q[15]) begin
      add_sum  = {1'b0, a_m_q} + {1'b0, b_m_q};
      add_sign = a_q[15];
    end else if (a_m_q >= b_m_q) begin
      add_sum  = {1'b0, a_m_q} - {1'b0, b_m_q};
      add_sign = a_q[15];
    end else begin
      add_sum  = {1'b0, b_m_q} - {1'b0, a_m_q};
      add_sign = b_q[15];
    end
    if (add_sum == '0) add_sign = 1'b0;
  end

  // Next-state and datapath update for the operation FSM.
  always_comb begin
    state_d = state_q;
    a_ack_d = a_ack_q;
    b_ack_d = b_ack_q;
    z_stb_d = z_stb_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    a_m_d   = a_m_q;
    b_m_d   = b_m_q;
    a_e_d   = a_e_q;
    b_e_d   = b_e_q;
    s_m_d   = s_m_q;
    s_e_d   = s_e_q;
    s_s_d   = s_s_q;
    unique case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_m_d = {|a_q[14:10], a_q[9:0], 3'b000};
        b_m_d = {|b_q[14:10], b_q[9:0], 3'b000};
        a_e_d = (a_q[14:10] == 5'd0) ? EMIN :
                $signed({2'b00, a_q[14:10]}) - EMAX;
        b_e_d = (b_q[14:10] == 5'd0) ? EMIN :
                $signed({2'b00, b_q[14:10]}) - EMAX;
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan || b_nan) begin
          z_d = QNAN;
        end else if (a_inf) begin
          z_d = (b_inf && (a_q[15] != b_q[15])) ? QNAN : a_q;
        end else if (b_inf) begin
          z_d = b_q;
        end else if (a_zero && b_zero) begin
          z_d = {a_q[15] & b_q[15], 15'd0};
        end else if (a_zero) begin
          z_d = b_q;
        end else if (b_zero) begin
          z_d = a_q;
        end else begin
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (a_e_q > b_e_q) begin
          b_m_d = {1'b0, b_m_q[13:2], b_m_q[1] | b_m_q[0]};
          b_e_d = b_e_q + 7'sd1;
        end else if (a_e_q < b_e_q) begin
          a_m_d = {1'b0, a_m_q[13:2], a_m_q[1] | a_m_q[0]};
          a_e_d = a_e_q + 7'sd1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        s_m_d   = add_sum;
        s_s_d   = add_sign;
        s_e_d   = a_e_q;
        state_d = NORM_0;
      end
      NORM_0: begin
        if (s_m_q[14]) begin
          s_m_d = {1'b0, s_m_q[14:2], s_m_q[1] | s_m_q[0]};
          s_e_d = s_e_q + 7'sd1;
        end
        state_d = NORM_1;
      end
      NORM_1: begin
        if (!s_m_q[13] && (s_e_q > EMIN)) begin
          s_m_d = {s_m_q[13:0], 1'b0};
          s_e_d = s_e_q - 7'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (rnd_up) begin
          if (rnd[11]) begin
            s_m_d = {1'b0, 11'h400, 3'b000};
            s_e_d = s_e_q + 7'sd1;
          end else begin
            s_m_d = {1'b0, rnd[10:0], s_m_q[2:0]};
          end
        end
        state_d = PACK;
      end
      PACK: begin
        if ((s_e_q == EMIN) && !s_m_q[13]) begin
          z_d = {s_s_q, 5'd0, s_m_q[12:3]};
        end else if (s_e_q > EMAX) begin
          z_d = {s_s_q, 5'h1f, 10'd0};
        end else begin
          z_d = {s_s_q, s_e_q[4:0] + 5'd15, s_m_q[12:3]};
        end
        state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = 1'b1;
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // Control state: reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  // Datapath registers; the result register holds through reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    z_q   <= z_d;
    a_m_q <= a_m_d;
    b_m_q <= b_m_d;
    a_e_q <= a_e_d;
    b_e_q <= b_e_d;
    s_m_q <= s_m_d;
    s_e_q <= s_e_d;
    s_s_q <= s_s_d;
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_q;

endmodule
